// File: rtl/inv_shift_sub_bytes_iter.sv
// inv_shift_sub_bytes_iter
//   Iterative AES InvShiftRows + InvSubBytes stage for one 128-bit state.
//   The state is captured (optionally row-shifted) into a working register,
//   then LANES bytes per cycle are pushed through inverse_sbox instances.
//   Byte i of a state is bits [127-8i -: 8]; byte r+4c is row r, column c.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   in_data    128-bit input state
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts out_data
//   out_data   InvSubBytes(InvShiftRows(in_data))
//   busy       substitution in progress
//
// inverse_sbox
//   Combinational AES inverse S-box: SubByte = InvSbox(num).

module inverse_sbox (
    input  logic [7:0] num,
    output logic [7:0] SubByte
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign SubByte = INV_SBOX[num];
endmodule

// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a state; in_ready=1
// S_BUSY | substituting group r_cnt of the working register
// S_DONE | result valid; may hand off and capture the next state at once
module inv_shift_sub_bytes_iter #(
    parameter int LANES       = 4,
    parameter bit APPLY_SHIFT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NGRP = 16 / LANES;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_work;

    logic          w_accept;
    logic          w_last;
    logic [7:0]    w_in_b   [16];
    logic [7:0]    w_work_b [16];
    logic [7:0]    w_sub_b  [16];
    logic [127:0]  w_isr;
    logic [127:0]  w_sub;
    logic [127:0]  w_capture;
    logic [3:0]    w_idx      [LANES];
    logic [7:0]    w_lane_in  [LANES];
    logic [7:0]    w_lane_out [LANES];

    // Byte views; InvShiftRows maps out (r,c) <- in (r,(c-r) mod 4).
    for (genvar i = 0; i < 16; i++) begin : g_bytes
        assign w_in_b[i]                = in_data[127-8*i -: 8];
        assign w_work_b[i]              = r_work[127-8*i -: 8];
        assign w_sub[127-8*i -: 8]      = w_sub_b[i];
        assign w_isr[127-8*i -: 8]      = w_in_b[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)];
    end

    assign w_capture = APPLY_SHIFT ? w_isr : in_data;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == LAST_GRP);

    // Group r_cnt covers bytes r_cnt*LANES .. r_cnt*LANES+LANES-1.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l]     = 4'(int'(r_cnt) * LANES + l);
        assign w_lane_in[l] = w_work_b[w_idx[l]];

        inverse_sbox u_isbox (
            .num     (w_lane_in[l]),
            .SubByte (w_lane_out[l])
        );
    end

    always_comb begin
        w_sub_b = w_work_b;
        for (int l = 0; l < LANES; l++) begin
            w_sub_b[w_idx[l]] = w_lane_out[l];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_BUSY;
            S_BUSY: if (w_last)   w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = in_valid ? S_BUSY : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs; in_ready in DONE follows out_ready so a hand-off and a new
    // capture can share one edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign out_data = r_work;

    // Working register and group counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= w_capture;
            r_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            r_work <= w_sub;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_inv_shift_sub_bytes_iter.sv
// Bench for inv_shift_sub_bytes_iter: four instances cover LANES=4/1/16
// with InvShiftRows, and LANES=4 without it.
module tb_inv_shift_sub_bytes_iter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   iv, ir, ov, orr, bz;
    logic [127:0] id [4];
    logic [127:0] od [4];
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] V1   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] EXP1 = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] V2   = {4{32'h637c00ff}};
    localparam logic [127:0] EXP2 = {4{32'h0001527d}};

    always #5 clk = ~clk;

    inv_shift_sub_bytes_iter #(.LANES(4), .APPLY_SHIFT(1'b1)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]), .busy(bz[0]));
    inv_shift_sub_bytes_iter #(.LANES(1), .APPLY_SHIFT(1'b1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .busy(bz[1]));
    inv_shift_sub_bytes_iter #(.LANES(16), .APPLY_SHIFT(1'b1)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .busy(bz[2]));
    inv_shift_sub_bytes_iter #(.LANES(4), .APPLY_SHIFT(1'b0)) u_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .busy(bz[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: GF(2^8) inverse of the inverse affine transform.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_isbox(input logic [7:0] x);
        logic [7:0] y, r;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, y);
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input bit shift);
        logic [7:0]   b [16];
        logic [127:0] o;
        int           src;
        for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = shift ? r + 4 * ((c - r + 4) % 4) : r + 4 * c;
                o[127-8*(r+4*c) -: 8] = m_isbox(b[src]);
            end
        end
        return o;
    endfunction

    task automatic run_one(input int k, input logic [127:0] data, input logic [127:0] exp,
                           input int lat, input string tag);
        int n;
        orr[k] = 1'b1;
        iv[k]  = 1'b1;
        id[k]  = data;
        tick();
        iv[k] = 1'b0;
        n = 0;
        while (!ov[k] && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk({tag, "_data"}, od[k], exp);
        tick();
    endtask

    task automatic stream(input int k, input int lanes, input string tag);
        logic [127:0] vec [8];
        logic [127:0] snap;
        int sent, got, cyc, last;
        bit acc, oacc;
        for (int i = 0; i < 8; i++) vec[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; got = 0; cyc = 0; last = 0;
        orr[k] = 1'b1;
        while (got < 8 && cyc < 400) begin
            iv[k] = (sent < 8);
            id[k] = vec[sent % 8];
            #1;
            acc  = iv[k] & ir[k];
            oacc = ov[k] & orr[k];
            snap = od[k];
            tick();
            cyc++;
            if (acc) sent++;
            if (oacc) begin
                chk({tag, "_data"}, snap, model(vec[got], 1'b1));
                if (got > 0) chk({tag, "_gap"}, 128'(cyc - last), 128'(16 / lanes + 1));
                last = cyc;
                got++;
            end
        end
        chk({tag, "_count"}, 128'(got), 128'd8);
        iv[k] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        iv = '0;
        orr = '0;
        for (int k = 0; k < 4; k++) id[k] = '0;
        #2;
        chk("rst_out_valid", 128'(ov[0]), 128'd0);
        chk("rst_out_data", od[0], 128'd0);
        chk("rst_busy", 128'(bz[0]), 128'd0);
        chk("rst_in_ready", 128'(ir[0]), 128'd1);
        iv[0] = 1'b1;
        id[0] = V1;
        tick();
        tick();
        chk("rst_ignore_busy", 128'(bz[0]), 128'd0);
        chk("rst_ignore_ready", 128'(ir[0]), 128'd1);
        iv[0] = 1'b0;
        rst_n = 1'b1;
        tick();

        // Capture, latency, and in_data churn during BUSY
        id[0] = V1;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        chk("cap_busy", 128'(bz[0]), 128'd1);
        chk("cap_ready", 128'(ir[0]), 128'd0);
        n = 0;
        while (!ov[0] && n < 40) begin
            id[0] = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
        end
        chk("l4_lat", 128'(n), 128'd4);
        chk("l4_data", od[0], EXP1);

        // Backpressure with a pending input
        iv[0] = 1'b1;
        id[0] = V2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 128'(ov[0]), 128'd1);
            chk("bp_data", od[0], EXP1);
            chk("bp_ready", 128'(ir[0]), 128'd0);
        end
        orr[0] = 1'b1;
        #1;
        chk("bp_ready_comb", 128'(ir[0]), 128'd1);
        tick();
        orr[0] = 1'b0;
        iv[0] = 1'b0;
        chk("bp_recap_busy", 128'(bz[0]), 128'd1);
        chk("bp_recap_valid", 128'(ov[0]), 128'd0);
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp2_lat", 128'(n), 128'd4);
        chk("bp2_data", od[0], EXP2);
        orr[0] = 1'b1;
        tick();
        chk("bp2_drop", 128'(ov[0]), 128'd0);
        chk("bp2_idle_ready", 128'(ir[0]), 128'd1);

        // Other lane counts and the shift bypass
        run_one(1, V1, EXP1, 16, "l1");
        run_one(2, V1, EXP1, 1, "l16");
        run_one(3, 128'd0, {16{8'h52}}, 4, "ns_zero");
        run_one(3, V2, EXP2, 4, "ns_pat");
        run_one(3, V1, model(V1, 1'b0), 4, "ns_v1");

        // Streaming
        stream(0, 4, "s4");
        stream(1, 1, "s1");
        stream(2, 16, "s16");

        // Reset mid-BUSY (cnt=2)
        orr[0] = 1'b1;
        id[0] = V2;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rb_valid", 128'(ov[0]), 128'd0);
        chk("rb_ready", 128'(ir[0]), 128'd1);
        chk("rb_busy", 128'(bz[0]), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_one(0, V1, EXP1, 4, "post_rb");

        // Reset mid-DONE
        orr[0] = 1'b0;
        id[0] = V2;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        chk("rd_pre_valid", 128'(ov[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rd_valid", 128'(ov[0]), 128'd0);
        chk("rd_data", od[0], 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_one(0, V2, EXP2, 4, "post_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
